// File: rtl/mem_cmd_responder.sv
// Command-driven memory responder: buffered write bursts drain into a local RAM,
// read bursts stream back one word per two cycles with valid/ready backpressure.
module mem_cmd_responder #(
  parameter int Nb    = 16,
  parameter int M_mem = 10,
  parameter int M_wb  = 6
) (
  input  logic          clk_core,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_instr,
  input  logic [6:0]    cmd_bl,
  input  logic [31:0]   cmd_addr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [Nb-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [Nb-1:0] rd_data,
  output logic          busy
);

  localparam int OFF_W     = M_mem - 2;
  localparam int WB_DEPTH  = 1 << M_wb;
  localparam int MEM_DEPTH = 1 << M_mem;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DRAIN = 2'd1,
    RD_REQ   = 2'd2,
    RD_OUT   = 2'd3
  } state_t;

  state_t           r_state;
  logic [6:0]       r_bl;
  logic [6:0]       r_idx;
  logic [1:0]       r_region;
  logic [OFF_W-1:0] r_base;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_rd_valid;
  logic [Nb-1:0]    r_rd_data;

  logic [Nb-1:0]    r_wb [WB_DEPTH];
  logic [M_wb-1:0]  r_wptr;
  logic [M_wb-1:0]  r_rptr;
  logic [M_wb:0]    r_count;

  logic [Nb-1:0]    r_mem [MEM_DEPTH];

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [OFF_W-1:0] w_offset;
  logic [M_mem-1:0] w_mem_addr;
  logic             w_unused_addr;

  assign w_unused_addr = &{1'b0, cmd_addr[29:OFF_W]};

  assign wr_ready  = (r_count < (M_wb+1)'(WB_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = wr_valid && wr_ready;
  assign w_pop     = (r_state == WR_DRAIN) && !w_empty;

  // Offset wraps inside the region; region bits stay fixed for the whole burst.
  assign w_offset   = r_base + OFF_W'(r_idx);
  assign w_mem_addr = {r_region, w_offset};

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bl        <= '0;
      r_idx       <= '0;
      r_region    <= '0;
      r_base      <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_bl        <= cmd_bl;
            r_idx       <= '0;
            r_region    <= cmd_addr[31:30];
            r_base      <= cmd_addr[OFF_W-1:0];
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= cmd_instr ? RD_REQ : WR_DRAIN;
          end
        end
        WR_DRAIN: begin
          if (!w_empty) begin
            if (r_idx == r_bl) begin
              r_state     <= IDLE;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_idx <= r_idx + 7'd1;
            end
          end
        end
        RD_REQ: begin
          r_state    <= RD_OUT;
          r_rd_valid <= 1'b1;
        end
        RD_OUT: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            if (r_idx == r_bl) begin
              r_state     <= IDLE;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_idx   <= r_idx + 7'd1;
              r_state <= RD_REQ;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rd_valid  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + M_wb'(1);
      if (w_pop)  r_rptr <= r_rptr + M_wb'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (M_wb+1)'(1);
        2'b01:   r_count <= r_count - (M_wb+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (w_push) r_wb[r_wptr] <= wr_data;
  end

  // The reset gate stops an in-flight drain from committing on the reset edge.
  always_ff @(posedge clk_core) begin
    if (w_pop && !reset) r_mem[w_mem_addr] <= r_wb[r_rptr];
  end

  // Read data only updates in RD_REQ, so it holds while the consumer stalls.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (r_state == RD_REQ) begin
      r_rd_data <= r_mem[w_mem_addr];
    end
  end

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed bench for mem_cmd_responder: drives on the falling edge, samples on
// the falling edge, and compares against hand-computed expected words.
module tb_mem_cmd_responder;

  logic        clk_core = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_instr;
  logic [6:0]  cmd_bl;
  logic [31:0] cmd_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        busy;

  int checkCount = 0;
  int errorCount = 0;
  logic [15:0] expWords [0:127];

  localparam int LIMIT = 1000;

  mem_cmd_responder #(.Nb(16), .M_mem(10), .M_wb(6)) dut (
    .clk_core  (clk_core),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_instr (cmd_instr),
    .cmd_bl    (cmd_bl),
    .cmd_addr  (cmd_addr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, "_wr_ready"},  wr_ready,  1);
    checkOutput({tag, "_rd_valid"},  rd_valid,  0);
    checkOutput({tag, "_rd_data"},   rd_data,   0);
    checkOutput({tag, "_busy"},      busy,      0);
  endtask

  task automatic pushWord(input logic [15:0] d);
    int n = 0;
    while (!wr_ready && n < LIMIT) begin
      @(negedge clk_core);
      n++;
    end
    checkOutput("push_ready", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk_core);
    wr_valid = 1'b0;
  endtask

  task automatic issueCmd(input logic instr, input logic [6:0] bl, input logic [31:0] addr);
    int n = 0;
    while (!cmd_ready && n < LIMIT) begin
      @(negedge clk_core);
      n++;
    end
    checkOutput("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_instr = instr;
    cmd_bl    = bl;
    cmd_addr  = addr;
    @(negedge clk_core);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk_core);
      n++;
    end
    checkOutput("idle_wait", busy, 0);
  endtask

  // One word per falling edge with rd_valid high, since rd_ready is held high.
  task automatic collectWords(input int count);
    int got = 0;
    int cyc = 0;
    rd_ready = 1'b1;
    while (got < count && cyc < LIMIT) begin
      if (rd_valid) begin
        checkOutput($sformatf("rd_word%0d", got), rd_data, expWords[got]);
        got++;
      end
      @(negedge clk_core);
      cyc++;
    end
    rd_ready = 1'b0;
    checkOutput("rd_count", got, count);
    checkOutput("rd_done_busy", busy, 0);
  endtask

  task automatic readBurst(input logic [6:0] bl, input logic [31:0] addr);
    issueCmd(1'b1, bl, addr);
    collectWords(int'(bl) + 1);
  endtask

  task automatic applyStimulus();
    int n;

    cmd_valid = 0; cmd_instr = 0; cmd_bl = 0; cmd_addr = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    reset = 1'b1;
    @(negedge clk_core);
    @(negedge clk_core);
    reset = 1'b0;
    checkResetValues("reset");

    $display("[TB] basic write then read burst");
    pushWord(16'h1111); pushWord(16'h2222); pushWord(16'h3333); pushWord(16'h4444);
    issueCmd(1'b0, 7'd3, 32'h0000_0010);
    waitIdle();
    issueCmd(1'b1, 7'd3, 32'h0000_0010);
    checkOutput("rd_lat_first", rd_valid, 0);
    checkOutput("rd_cmd_ready_low", cmd_ready, 0);
    checkOutput("rd_busy_high", busy, 1);
    @(negedge clk_core);
    checkOutput("rd_lat_second", rd_valid, 1);
    expWords[0] = 16'h1111; expWords[1] = 16'h2222;
    expWords[2] = 16'h3333; expWords[3] = 16'h4444;
    collectWords(4);

    $display("[TB] region wrap");
    pushWord(16'hAAAA); pushWord(16'hBBBB);
    issueCmd(1'b0, 7'd1, 32'h0000_00FF);
    waitIdle();
    pushWord(16'hC0C0); pushWord(16'hD0D0);
    issueCmd(1'b0, 7'd1, 32'h4000_00FF);
    waitIdle();
    expWords[0] = 16'hD0D0;
    readBurst(7'd0, 32'h4000_0000);
    expWords[0] = 16'hC0C0; expWords[1] = 16'hD0D0;
    readBurst(7'd1, 32'h4000_00FF);
    expWords[0] = 16'hAAAA; expWords[1] = 16'hBBBB;
    readBurst(7'd1, 32'h0000_00FF);

    $display("[TB] trickled write data");
    issueCmd(1'b0, 7'd7, 32'h0000_0040);
    for (int k = 0; k < 8; k++) begin
      repeat (2) begin
        checkOutput("trickle_hold", cmd_ready, 0);
        @(negedge clk_core);
      end
      pushWord(16'h3000 + 16'(k));
      checkOutput("trickle_pending", cmd_ready, 0);
    end
    @(negedge clk_core);
    checkOutput("trickle_done", cmd_ready, 1);
    for (int k = 0; k < 8; k++) expWords[k] = 16'h3000 + 16'(k);
    readBurst(7'd7, 32'h0000_0040);

    $display("[TB] full write buffer");
    for (int k = 0; k < 64; k++) pushWord(16'h0100 + 16'(k));
    checkOutput("wb_full", wr_ready, 0);
    issueCmd(1'b0, 7'd63, 32'h0000_0080);
    checkOutput("wb_full_accept", wr_ready, 0);
    @(negedge clk_core);
    checkOutput("wb_after_pop", wr_ready, 1);
    waitIdle();
    for (int k = 0; k < 64; k++) expWords[k] = 16'h0100 + 16'(k);
    readBurst(7'd63, 32'h0000_0080);

    $display("[TB] read backpressure");
    rd_ready = 1'b0;
    issueCmd(1'b1, 7'd2, 32'h0000_0010);
    n = 0;
    while (!rd_valid && n < LIMIT) begin
      @(negedge clk_core);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid", rd_valid, 1);
      checkOutput("bp_data", rd_data, 16'h1111);
      @(negedge clk_core);
    end
    expWords[0] = 16'h1111; expWords[1] = 16'h2222; expWords[2] = 16'h3333;
    collectWords(3);

    $display("[TB] reset during write drain");
    pushWord(16'h5550); pushWord(16'h5551); pushWord(16'h5552); pushWord(16'h5553);
    issueCmd(1'b0, 7'd3, 32'h0000_0020);
    waitIdle();
    pushWord(16'h6660); pushWord(16'h6661); pushWord(16'h6662); pushWord(16'h6663);
    issueCmd(1'b0, 7'd3, 32'h0000_0020);
    @(negedge clk_core);
    @(negedge clk_core);
    reset = 1'b1;
    @(negedge clk_core);
    reset = 1'b0;
    checkResetValues("midreset");
    issueCmd(1'b0, 7'd0, 32'h0000_0030);
    repeat (3) @(negedge clk_core);
    checkOutput("discard_stall", busy, 1);
    pushWord(16'h7777);
    waitIdle();
    expWords[0] = 16'h6660; expWords[1] = 16'h6661;
    expWords[2] = 16'h5552; expWords[3] = 16'h5553;
    readBurst(7'd3, 32'h0000_0020);
    expWords[0] = 16'h7777;
    readBurst(7'd0, 32'h0000_0030);
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mem_cmd_responder.md
MEM_CMD_RESPONDER -- requirements
Module: mem_cmd_responder

Interface
REQ-001 SHALL have parameter Nb, default 16: data word width in bits.
REQ-002 SHALL have parameter M_mem, default 10: log2 of memory depth in words (1024 words).
REQ-003 SHALL have parameter M_wb, default 6: log2 of write-buffer depth (64 words).
REQ-004 SHALL have port clk_core, input, 1 bit: core clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have cmd_valid in 1 / cmd_ready out 1: command handshake.
REQ-007 SHALL have cmd_instr in 1: 0 = write, 1 = read.
REQ-008 SHALL have cmd_bl in 7: burst length minus one (1..128 words).
REQ-009 SHALL have cmd_addr in 32: [31:30] port region, [M_mem-3:0] word offset, other bits ignored.
REQ-010 SHALL have wr_valid in 1 / wr_ready out 1 / wr_data in Nb: write-data stream into the write buffer.
REQ-011 SHALL have rd_valid out 1 / rd_ready in 1 / rd_data out Nb: read-data stream.
REQ-012 SHALL have busy out 1: high whenever state is not IDLE.

Function
REQ-013 SHALL transfer on any channel only on a cycle where valid and ready are both high at the rising edge.
REQ-014 SHALL hold internal memory of 2^M_mem x Nb words with 1-cycle synchronous read; contents are not reset.
REQ-015 SHALL map command address to memory index {cmd_addr[31:30], offset}, where offset is M_mem-2 bits.
REQ-016 SHALL increment the offset per word modulo 2^(M_mem-2); region bits never change within a burst (wrap stays in region).
REQ-017 SHALL implement a write-buffer FIFO of 2^M_wb words; wr_ready = (count < 2^M_wb), independent of state.
REQ-018 SHALL allow write data to arrive before, during or after the write command; buffer push and pop in the same cycle keep count unchanged.
REQ-019 SHALL implement states IDLE, WR_DRAIN, RD_REQ, RD_OUT.
REQ-020 SHALL drive cmd_ready = 1 only in IDLE; on accept, latch cmd_bl, base index and instr; move to WR_DRAIN if instr = 0, else RD_REQ.
REQ-021 WR_DRAIN SHALL pop one buffer word per cycle when the buffer is non-empty and write it to mem[base+i]. It SHALL stall with no write while the buffer is empty.
REQ-022 WR_DRAIN SHALL return to IDLE on the edge that pops word cmd_bl (the (cmd_bl+1)-th word), so cmd_ready is high the next cycle.
REQ-023 RD_REQ SHALL present address base+i to the memory and move to RD_OUT; in RD_OUT rd_valid = 1 and rd_data = mem word.
REQ-024 rd_data SHALL be held stable while rd_valid & !rd_ready.
REQ-025 On a read handshake, RD_OUT SHALL go to IDLE if i = cmd_bl, else increment i and go to RD_REQ. Throughput is 1 word per 2 cycles without backpressure.
REQ-026 First rd_valid SHALL rise after the second rising edge following command acceptance.
REQ-027 Because commands are serialized, a read accepted after a write completes SHALL return the newly written data.
REQ-028 Burst counter i SHALL be 7 bits; bursts longer than the buffer depth SHALL complete by streaming.

Reset
REQ-029 Reset SHALL force state IDLE, i = 0, and write buffer empty; memory contents are retained.
REQ-030 After reset, outputs SHALL be cmd_ready = 1, wr_ready = 1, rd_valid = 0, rd_data = 0, busy = 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst and discard buffered write data; the first post-reset cycle obeys REQ-030.

Verification
REQ-032 Push 4 words 0x1111..0x4444, then write cmd bl=3 addr=0x0000_0010, then read cmd bl=3 same addr -> rd stream 0x1111,0x2222,0x3333,0x4444; busy low afterwards.
REQ-033 Write cmd bl=1 addr=0x4000_00FF with M_mem=10 -> words land at region 1 offsets 0xFF and 0x00; read-back of region 0 offsets 0xFF/0x00 unchanged.
REQ-034 Write cmd bl=7 accepted with empty buffer, data trickled 1 word every 3 cycles -> cmd_ready stays 0 until the 8th pop, then 1 next cycle.
REQ-035 Push 64 words with no command -> wr_ready = 0 at count 64. Then write cmd bl=63 -> wr_ready = 1 the cycle after the first pop.
REQ-036 Read bl=2 with rd_ready held low 5 cycles on word 0 -> rd_data stable, no words lost or duplicated.
REQ-037 Reset pulsed in WR_DRAIN after 2 of 4 pops -> REQ-030 values; subsequent read of those offsets returns the 2 written words plus prior contents.
